key_debounce: RTL and testbench

- Upstream front end of the piano voice path: conditions the eight raw key contacts t0..t7 before the chord reaches the chord-capture and frequency-lookup stage.
- Per key: 2-flop synchronizer, then a stability counter.
- Presents a clean debounced chord vector plus a valid/ready change notification, so the downstream state machine latches a new chord only when the key set actually changes.

---
 rtl/piano_pkg.sv | 19 +
 rtl/key_debounce_if.sv | 23 ++
 rtl/debounce_cell.sv | 55 +++++
 rtl/key_debounce.sv | 57 +++++
 tb/tb_key_debounce.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/piano_pkg.sv
// Shared constants for the piano voice path: key count, chord bit indices and
// debounce defaults used by key_debounce and the downstream chord-capture stage.
package piano_pkg;

    localparam int unsigned N_KEYS         = 8;
    localparam int unsigned DB_CYCLES_DEF  = 50000;
    localparam int unsigned CNT_W_DEF      = 16;

    // Chord vector is {t0..t7}, so t0 sits in the MSB.
    localparam int unsigned KEY_T0 = 7;
    localparam int unsigned KEY_T1 = 6;
    localparam int unsigned KEY_T2 = 5;
    localparam int unsigned KEY_T3 = 4;
    localparam int unsigned KEY_T4 = 3;
    localparam int unsigned KEY_T5 = 2;
    localparam int unsigned KEY_T6 = 1;
    localparam int unsigned KEY_T7 = 0;

endpackage

// File: rtl/key_debounce_if.sv
// Debounced chord plus valid/ready change notification between key_debounce
// (master) and the chord-capture consumer (slave).
interface key_debounce_if #(
    parameter int unsigned N_KEYS = piano_pkg::N_KEYS
);

    logic [N_KEYS-1:0] chord;
    logic              chg_valid;
    logic              chg_ready;

    modport master (
        output chord,
        output chg_valid,
        input  chg_ready
    );

    modport slave (
        input  chord,
        input  chg_valid,
        output chg_ready
    );

endinterface

// File: rtl/debounce_cell.sv
// One key: 2-flop synchronizer, stability counter and accepted level. key_chg_o
// pulses for the single cycle in which a new level is committed to stable_o.
module debounce_cell
    import piano_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_raw_i,
    output logic stable_o,
    output logic key_chg_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_chg;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        key_chg  = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            key_chg  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o  = stable_q;
    assign key_chg_o = key_chg;

endmodule

// File: rtl/key_debounce.sv
// Debounces the raw key contacts and raises chg_valid whenever the debounced
// chord changes; changes arriving while a notification is pending coalesce.
module key_debounce
    import piano_pkg::*;
#(
    parameter int unsigned N_KEYS    = piano_pkg::N_KEYS,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keys_raw,
    key_debounce_if.master    chg
);

    logic [N_KEYS-1:0] stable;
    logic [N_KEYS-1:0] key_chg;
    logic              any_chg;
    logic              chg_valid_q, chg_valid_d;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_cell
        debounce_cell #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_cell (
            .clk_i     (clk),
            .rst_i     (rst),
            .key_raw_i (keys_raw[i]),
            .stable_o  (stable[i]),
            .key_chg_o (key_chg[i])
        );
    end

    assign any_chg = |key_chg;

    // A fresh change wins over a simultaneous handshake so it is never lost.
    always_comb begin
        chg_valid_d = chg_valid_q;
        if (any_chg) begin
            chg_valid_d = 1'b1;
        end else if (chg_valid_q && chg.chg_ready) begin
            chg_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_valid_q <= 1'b0;
        end else begin
            chg_valid_q <= chg_valid_d;
        end
    end

    assign chg.chord     = stable;
    assign chg.chg_valid = chg_valid_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES = 4; expected chords are queued
// at stimulus time and popped by a monitor on every valid/ready handshake.
module tb_key_debounce;

    localparam int unsigned NK = 8;
    localparam int unsigned DB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] keys_raw;

    key_debounce_if #(.N_KEYS(NK)) chg ();

    key_debounce #(
        .N_KEYS    (NK),
        .DB_CYCLES (DB),
        .CNT_W     (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .keys_raw (keys_raw),
        .chg      (chg)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [NK-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every handshake must match the next queued chord.
    always @(negedge clk) begin
        if (!rst && chg.chg_valid && chg.chg_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got chord %0h, required no pending change",
                         chg.chord);
            end else begin
                check("sb_chord", 32'(chg.chord), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic seen;
        logic bad;

        rst           = 1'b1;
        keys_raw      = '0;
        chg.chg_ready = 1'b1;
        tick(2);
        check("reset_chord", 32'(chg.chord), 32'h00);
        check("reset_valid", 32'(chg.chg_valid), 32'h0);
        rst = 1'b0;

        // Idle after reset: nothing may happen.
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (chg.chg_valid) seen = 1'b1;
        end
        check("idle_valid", 32'(seen), 32'h0);
        check("idle_chord", 32'(chg.chord), 32'h00);

        // Latency: drive at edge k, chord updates at edge k+6, valid for one cycle.
        keys_raw = 8'h81;
        exp_q.push_back(8'h81);
        tick(5);
        check("lat_early_chord", 32'(chg.chord), 32'h00);
        tick(1);
        check("lat_chord", 32'(chg.chord), 32'h81);
        check("lat_valid", 32'(chg.chg_valid), 32'h1);
        tick(1);
        check("lat_valid_drop", 32'(chg.chg_valid), 32'h0);

        keys_raw = 8'h00;
        exp_q.push_back(8'h00);
        tick(8);
        check("release_chord", 32'(chg.chord), 32'h00);

        // 3-cycle glitch is rejected.
        keys_raw = 8'h08;
        tick(3);
        keys_raw = 8'h00;
        tick(10);
        check("glitch3_chord", 32'(chg.chord), 32'h00);
        check("glitch3_valid", 32'(chg.chg_valid), 32'h0);

        // 4-cycle pulse is accepted, then released.
        keys_raw = 8'h08;
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h00);
        tick(4);
        keys_raw = 8'h00;
        tick(2);
        check("pulse4_chord", 32'(chg.chord), 32'h08);
        check("pulse4_valid", 32'(chg.chg_valid), 32'h1);
        tick(4);
        check("pulse4_back_chord", 32'(chg.chord), 32'h00);
        tick(2);
        check("pulse4_idle_valid", 32'(chg.chg_valid), 32'h0);

        // Coalescing with the consumer stalled.
        chg.chg_ready = 1'b0;
        keys_raw      = 8'h01;
        bad           = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            if (i == 10) keys_raw = 8'h03;
            if (i >= 6 && !chg.chg_valid) bad = 1'b1;
        end
        check("coalesce_valid_held", 32'(bad), 32'h0);
        check("coalesce_chord", 32'(chg.chord), 32'h03);
        exp_q.push_back(8'h03);
        chg.chg_ready = 1'b1;
        tick(1);
        chg.chg_ready = 1'b0;
        check("coalesce_valid_drop", 32'(chg.chg_valid), 32'h0);

        // New key completes on the same edge as a handshake.
        keys_raw = 8'h07;
        tick(6);
        check("same_pre_chord", 32'(chg.chord), 32'h07);
        check("same_pre_valid", 32'(chg.chg_valid), 32'h1);
        keys_raw = 8'h0F;
        tick(5);
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h0F);
        chg.chg_ready = 1'b1;
        tick(1);
        check("same_edge_valid", 32'(chg.chg_valid), 32'h1);
        check("same_edge_chord", 32'(chg.chord), 32'h0F);
        tick(1);
        check("same_edge_drop", 32'(chg.chg_valid), 32'h0);

        // Asynchronous reset mid-count discards the partial count.
        keys_raw = 8'hFF;
        tick(4);
        #2 rst = 1'b1;
        #1;
        check("async_rst_chord", 32'(chg.chord), 32'h00);
        check("async_rst_valid", 32'(chg.chg_valid), 32'h0);
        tick(1);
        rst = 1'b0;
        exp_q.push_back(8'hFF);
        tick(5);
        check("post_rst_early_chord", 32'(chg.chord), 32'h00);
        check("post_rst_early_valid", 32'(chg.chg_valid), 32'h0);
        tick(1);
        check("post_rst_chord", 32'(chg.chord), 32'hFF);
        check("post_rst_valid", 32'(chg.chg_valid), 32'h1);
        tick(1);
        check("post_rst_drop", 32'(chg.chg_valid), 32'h0);

        tick(3);
        check("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
